// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared arbiter state encoding and response bundle
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, ABORT} arb_state_e;
  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_rsp_t;
endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker starting after the last owner
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // scan from farthest to nearest so the requester closest after last wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        gnt = '0;
        gnt[(int'(last) + i) % N] = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 master arbiter with stall watchdog
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_MASTERS = 2,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NR_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NR_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NR_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NR_MASTERS-1:0]      m_we_i,
  input  logic [NR_MASTERS-1:0]      m_cyc_i,
  input  logic [NR_MASTERS-1:0]      m_stb_i,
  output logic [DW-1:0]              m_dat_o,
  output logic [NR_MASTERS-1:0]      m_ack_o,
  output logic [NR_MASTERS-1:0]      m_err_o,
  output logic [NR_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]              s_adr_o,
  output logic [DW-1:0]              s_dat_o,
  output logic [DW/8-1:0]            s_sel_o,
  output logic                       s_we_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  input  logic [DW-1:0]              s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_rty_i,
  output logic [NR_MASTERS-1:0]      grant_o,
  output logic                       timeout_o
);
  localparam int IW = $clog2(NR_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO = (CW + 1)'(TIMEOUT);

  arb_state_e state, state_n;
  logic [NR_MASTERS-1:0] grant, grant_n, pick_gnt;
  logic [IW-1:0] gidx, gidx_n, last, last_n, pick_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0] cnt_inc;
  wb_rsp_t rsp;
  logic own, ab, owner_cyc, stall, expire;

  rr_pick #(.N(NR_MASTERS), .IW(IW)) u_pick (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign rsp       = '{ack: s_ack_i, err: s_err_i, rty: s_rty_i};
  assign own       = state == OWN;
  assign ab        = state == ABORT;
  assign owner_cyc = m_cyc_i[gidx];
  assign stall     = s_stb_o & ~(rsp.ack | rsp.err | rsp.rty);
  assign cnt_inc   = {1'b0, cnt} + (CW + 1)'(1);
  assign expire    = (TIMEOUT != 0) && stall && (cnt_inc == TO);

  assign s_adr_o   = own ? m_adr_i[AW*gidx +: AW] : '0;
  assign s_dat_o   = own ? m_dat_i[DW*gidx +: DW] : '0;
  assign s_sel_o   = own ? m_sel_i[(DW/8)*gidx +: DW/8] : '0;
  assign s_we_o    = own & m_we_i[gidx];
  assign s_cyc_o   = own & owner_cyc;
  assign s_stb_o   = own & m_stb_i[gidx];
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (own & rsp.ack) ? grant : '0;
  assign m_err_o   = (ab | (own & rsp.err)) ? grant : '0;
  assign m_rty_o   = (own & rsp.rty) ? grant : '0;
  assign grant_o   = grant;
  assign timeout_o = ab;

  // arbitration, release and watchdog decisions
  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n  = gidx;
    last_n  = last;
    cnt_n   = '0;
    if (state == IDLE) begin
      if (|m_cyc_i) begin
        state_n = OWN;
        grant_n = pick_gnt;
        gidx_n  = pick_idx;
      end
    end else if (state == OWN) begin
      if (!owner_cyc) begin
        state_n = IDLE;
        grant_n = '0;
        last_n  = gidx;
      end else if (expire) begin
        state_n = ABORT;
      end else begin
        cnt_n = stall ? cnt_inc[CW-1:0] : '0;
      end
    end else begin
      state_n = owner_cyc ? OWN : IDLE;
      grant_n = owner_cyc ? grant : '0;
      last_n  = owner_cyc ? last : gidx;
    end
  end

  // state, owner and watchdog registers; master 0 has first priority out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IW'(NR_MASTERS - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      gidx  <= gidx_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scenario tasks with a response scoreboard for wb_rr_arbiter
module tb_wb_rr_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [63:0] m_adr_i, m_dat_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_we_i, m_cyc_i, m_stb_i;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
  logic [31:0] m_dat_z, s_adr_z, s_dat_z;
  logic [1:0]  ack_z, err_z, rty_z, grant_z;
  logic [3:0]  sel_z;
  logic        we_z, cyc_z, stb_z, timeout_z;

  typedef struct {int m; logic [31:0] adr; logic [31:0] dat;} exp_t;
  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  wb_rr_arbiter #(.NR_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_rr_arbiter #(.NR_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(0)) dut_nowd (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_z), .m_ack_o(ack_z), .m_err_o(err_z), .m_rty_o(rty_z),
    .s_adr_o(s_adr_z), .s_dat_o(s_dat_z), .s_sel_o(sel_z), .s_we_o(we_z),
    .s_cyc_o(cyc_z), .s_stb_o(stb_z), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_o(grant_z), .timeout_o(timeout_z)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic set_master(input int m, input logic on, input logic [31:0] adr,
                            input logic [31:0] dat, input logic we);
    m_cyc_i[m] = on;
    m_stb_i[m] = on;
    m_we_i[m] = we;
    m_adr_i[32*m +: 32] = adr;
    m_dat_i[32*m +: 32] = dat;
    m_sel_i[4*m +: 4] = 4'hF;
  endtask

  task automatic idle_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  // slave acks each strobe on its second cycle; masters drop cyc after their ack
  task automatic run_bus(input int budget);
    logic [1:0] ackd;
    logic arm;
    int n, low_run;
    bit had_owner;
    arm = 0; n = 0; low_run = 0; had_owner = 0;
    while (sbq.size() > 0 && n < budget) begin
      @(negedge clk_i);
      ackd = m_ack_o;
      if (s_cyc_o) begin
        if (had_owner && low_run > 0) begin
          checks++;
          if (low_run != 2) begin
            errors++;
            $display("FAIL handover_gap: s_cyc low for %0d cycles, want 2", low_run);
          end
        end
        low_run = 0;
        had_owner = 1;
      end else if (had_owner) low_run++;
      if (|ackd) begin
        exp_t e = sbq.pop_front();
        checks++;
        if (ackd !== 2'(1 << e.m) || m_dat_o !== e.dat) begin
          errors++;
          $display("FAIL rr_order: ack=%b dat=%h, want ack=%b dat=%h", ackd, m_dat_o, 2'(1 << e.m), e.dat);
        end
      end
      arm = s_stb_o & ~s_ack_i;
      @(posedge clk_i); #1;
      s_ack_i = arm;
      s_dat_i = rd_data(s_adr_o);
      m_cyc_i &= ~ackd;
      m_stb_i &= ~ackd;
      n++;
    end
    if (sbq.size() > 0) begin
      checks++; errors++;
      $display("FAIL bus_budget: %0d transfers outstanding, want 0", sbq.size());
      sbq.delete();
    end
    s_ack_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1;
    idle_inputs();
    #1 rst_ni = 0;
    #2;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, timeout_o, m_ack_o, m_err_o, m_rty_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b cyc=%b stb=%b to=%b ack=%b err=%b, want all 0",
               grant_o, s_cyc_o, s_stb_o, timeout_o, m_ack_o, m_err_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  task automatic test_single_write();
    exp_t e;
    do_reset();
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    sbq.push_back('{m: 0, adr: 32'h0000_0010, dat: 32'hDEAD_BEEF});
    @(negedge clk_i);
    checks++;
    if (s_cyc_o !== 0 || grant_o !== 2'b00) begin
      errors++; $display("FAIL grant_latency_t: cyc=%b grant=%b, want 0 00", s_cyc_o, grant_o);
    end
    @(negedge clk_i);
    checks++;
    if (s_cyc_o !== 1 || grant_o !== 2'b01) begin
      errors++; $display("FAIL grant_latency_t1: cyc=%b grant=%b, want 1 01", s_cyc_o, grant_o);
    end
    @(negedge clk_i);
    checks++;
    if (m_ack_o !== 2'b00) begin
      errors++; $display("FAIL early_ack: ack=%b, want 00", m_ack_o);
    end
    @(posedge clk_i); #1 s_ack_i = 1;
    @(negedge clk_i);
    e = sbq.pop_front();
    checks++;
    if (m_ack_o !== 2'(1 << e.m) || s_adr_o !== e.adr || s_dat_o !== e.dat || s_we_o !== 1 || s_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL write_xfer: ack=%b adr=%h dat=%h we=%b sel=%h, want ack=%b adr=%h dat=%h we=1 sel=f",
               m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, 2'(1 << e.m), e.adr, e.dat);
    end
    @(posedge clk_i); #1;
    s_ack_i = 0;
    set_master(0, 0, 0, 0, 0);
    @(negedge clk_i);
    checks++;
    if (s_cyc_o !== 0) begin
      errors++; $display("FAIL release_comb: cyc=%b, want 0", s_cyc_o);
    end
  endtask

  task automatic test_both_masters();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      @(posedge clk_i); #1;
      set_master(0, 1, 32'h100 + r, 0, 0);
      set_master(1, 1, 32'h200 + r, 0, 0);
      sbq.push_back('{m: 0, adr: 32'h100 + r, dat: rd_data(32'h100 + r)});
      sbq.push_back('{m: 1, adr: 32'h200 + r, dat: rd_data(32'h200 + r)});
      run_bus(40);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h400, 0, 0);
    sbq.push_back('{m: 0, adr: 32'h400, dat: rd_data(32'h400)});
    run_bus(20);
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h500, 0, 0);
    set_master(1, 1, 32'h600, 0, 0);
    sbq.push_back('{m: 1, adr: 32'h600, dat: rd_data(32'h600)});
    sbq.push_back('{m: 0, adr: 32'h500, dat: rd_data(32'h500)});
    run_bus(40);
  endtask

  task automatic test_timeout();
    logic [3:0] want;
    do_reset();
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h40, 0, 0);
    set_master(1, 1, 32'h80, 0, 0);
    @(negedge clk_i);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      want = (k == 4) ? 4'b0_1_01 : 4'b1_0_00;
      checks++;
      if ({s_cyc_o, timeout_o, m_err_o} !== want || grant_o !== 2'b01) begin
        errors++;
        $display("FAIL abort_k%0d: cyc,to,err=%b grant=%b, want %b 01", k, {s_cyc_o, timeout_o, m_err_o}, grant_o, want);
      end
    end
    @(posedge clk_i); #1;
    m_cyc_i = '0; m_stb_i = '0;
  endtask

  task automatic test_ack_last_stall();
    logic [4:0] want;
    do_reset();
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h44, 0, 0);
    @(negedge clk_i);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk_i); #1 s_ack_i = (k == 3);
      @(negedge clk_i);
      want = {(k == 3) ? 2'b01 : 2'b00, (k == 8) ? 2'b01 : 2'b00, k == 8};
      checks++;
      if ({m_ack_o, m_err_o, timeout_o} !== want) begin
        errors++;
        $display("FAIL ack_wins_k%0d: ack,err,to=%b, want %b", k, {m_ack_o, m_err_o, timeout_o}, want);
      end
    end
    @(posedge clk_i); #1;
    s_ack_i = 0; m_cyc_i = '0; m_stb_i = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk_i); #1;
    set_master(0, 1, 32'h300, 0, 0);
    sbq.push_back('{m: 0, adr: 32'h300, dat: rd_data(32'h300)});
    run_bus(20);
    @(posedge clk_i); #1 set_master(0, 1, 32'h310, 0, 0);
    @(negedge clk_i);
    @(posedge clk_i); #1 set_master(1, 1, 32'h320, 0, 0);
    @(negedge clk_i);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL mid_owner: grant=%b, want 01", grant_o);
    end
    #2 rst_ni = 0;
    #1;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, timeout_o, m_ack_o, m_err_o} !== '0 || s_adr_o !== '0) begin
      errors++;
      $display("FAIL async_reset: grant=%b cyc=%b stb=%b adr=%h, want 0", grant_o, s_cyc_o, s_stb_o, s_adr_o);
    end
    @(posedge clk_i); #1 rst_ni = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (grant_o !== 2'b01) begin
      errors++; $display("FAIL post_reset_grant: grant=%b, want 01", grant_o);
    end
    @(posedge clk_i); #1;
    m_cyc_i = '0; m_stb_i = '0;
  endtask

  task automatic test_no_watchdog();
    int bad = 0;
    do_reset();
    @(posedge clk_i); #1 set_master(0, 1, 32'h700, 0, 0);
    @(negedge clk_i);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      if (timeout_z !== 0 || err_z !== 2'b00 || cyc_z !== 1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL no_watchdog: %0d aborted cycles, want 0", bad);
    end
    @(posedge clk_i); #1 s_ack_i = 1;
    @(negedge clk_i);
    checks++;
    if (ack_z !== 2'b01) begin
      errors++; $display("FAIL late_ack: ack=%b, want 01", ack_z);
    end
    @(posedge clk_i); #1;
    s_ack_i = 0; m_cyc_i = '0; m_stb_i = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_both_masters();
    test_rotation();
    test_timeout();
    test_ack_last_stall();
    test_reset_mid();
    test_no_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
